pll_lock_sequencer: RTL and testbench

- Supervises an iCE40 SB_PLL40_CORE instance: drives its RESETB and BYPASS pins and monitors its LOCK output.
- Holds the PLL in reset, waits for lock with a timeout, then requires lock to stay stable before asserting `ready`.
- On lock loss it retries a bounded number of times before declaring a fault.
- Runs on the free-running reference clock (the PLL input, 22.5 MHz on the board); `ready` gates release of downstream resets in the PLL output domain.

---
 rtl/pll_lock_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: drives an SB_PLL40_CORE's RESETB/BYPASS pins and watches LOCK.
// It holds the PLL in reset, waits for lock with a timeout and requires lock to stay
// stable before raising ready. Lock failures are retried a bounded number of times
// before the block parks in FAULT.
// Optional feature macro: PLL_BYPASS_FALLBACK_EN. When it is defined, FAULT runs
// the PLL in bypass so that downstream logic can keep going on the reference clock.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 22500,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                               clock_in,
  input  logic                               reset_n,
  input  logic                               restart,
  input  logic                               pll_locked,
  output logic                               pll_resetb,
  output logic                               pll_bypass,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  ResetLast   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  // The shared counter must reach every terminal count without wrapping.
  localparam longint unsigned CntSpan = 64'd1 << CNT_W;
  localparam bit ParamsOk = (CntSpan > 64'(RESET_CYCLES)) &&
                            (CntSpan > 64'(LOCK_TIMEOUT)) &&
                            (CntSpan > 64'(STABLE_CYCLES)) &&
                            (RESET_CYCLES >= 1) && (MAX_RETRIES >= 1);

  if (!ParamsOk) begin : g_param_check
    $error("pll_lock_sequencer: CNT_W too narrow or RESET_CYCLES/MAX_RETRIES below 1");
  end

  typedef enum logic [2:0] {
    StResetHold,
    StWaitLock,
    StStabilize,
    StRun,
    StFault
  } state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_next_cnt;
  logic [RetryW-1:0]   r_retry;
  logic [RetryW-1:0]   w_next_retry;
  logic                r_sync1;
  logic                r_sync2;
  logic                w_locked_s;
  logic                w_retry_path;
  logic                w_lock_lost_d;
  logic                w_resetb_d;
  logic                w_bypass_d;
  logic                w_ready_d;
  logic                w_fault_d;
  logic                r_pll_resetb;
  logic                r_pll_bypass;
  logic                r_ready;
  logic                r_fault;
  logic                r_lock_lost;

  assign w_locked_s = r_sync2;

  // Two-flop synchronizer for the asynchronous PLL LOCK signal.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and retry bookkeeping; restart overrides everything.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_retry  = r_retry;
    w_retry_path  = 1'b0;
    w_lock_lost_d = 1'b0;
    if (restart) begin
      w_next_state = StResetHold;
      w_next_cnt   = '0;
      w_next_retry = '0;
    end else begin
      unique case (r_state)
        StResetHold: begin
          if (r_cnt == ResetLast) begin
            w_next_state = StWaitLock;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        StWaitLock: begin
          if (w_locked_s) begin
            w_next_state = StStabilize;
            w_next_cnt   = '0;
          end else if (r_cnt == TimeoutLast) begin
            w_retry_path = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        StStabilize: begin
          // A drop on the final stable cycle still counts as a failure.
          if (!w_locked_s) begin
            w_retry_path = 1'b1;
          end else if (r_cnt == StableLast) begin
            w_next_state = StRun;
            w_next_cnt   = '0;
            w_next_retry = '0;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        StRun: begin
          if (!w_locked_s) begin
            w_lock_lost_d = 1'b1;
            w_retry_path  = 1'b1;
          end
        end
        StFault: begin
          w_next_state = StFault;
        end
        default: begin
          w_next_state = StResetHold;
          w_next_cnt   = '0;
        end
      endcase

      if (w_retry_path) begin
        w_next_cnt = '0;
        if (r_retry == RetryMax) begin
          w_next_state = StFault;
        end else begin
          w_next_retry = r_retry + 1'b1;
          w_next_state = StResetHold;
        end
      end
    end
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    w_resetb_d = (w_next_state == StWaitLock) || (w_next_state == StStabilize) ||
                 (w_next_state == StRun);
    w_ready_d  = (w_next_state == StRun);
    w_fault_d  = (w_next_state == StFault);
    w_bypass_d = 1'b0;
`ifdef PLL_BYPASS_FALLBACK_EN
    if (w_next_state == StFault) begin
      w_resetb_d = 1'b1;
      w_bypass_d = 1'b1;
      w_ready_d  = 1'b1;
    end
`endif
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StResetHold;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_pll_bypass <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_retry      <= w_next_retry;
      r_pll_resetb <= w_resetb_d;
      r_pll_bypass <= w_bypass_d;
      r_ready      <= w_ready_d;
      r_fault      <= w_fault_d;
      r_lock_lost  <= w_lock_lost_d;
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign pll_bypass  = r_pll_bypass;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized lock/restart
// activity. A phase-level reference model predicts every cycle's outputs into a
// queue; a negedge monitor pops and compares against the DUT.
module tb_pll_lock_sequencer;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned SC = 8;
  localparam int unsigned MR = 2;
  localparam int unsigned RW = $clog2(MR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          locked = 1'b0;
  logic          pll_resetb;
  logic          pll_bypass;
  logic          ready;
  logic          fault;
  logic          lock_lost;
  logic [RW-1:0] retry_count;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .CNT_W        (8)
  ) dut (
    .clock_in   (clk),
    .reset_n    (rst_n),
    .restart    (restart),
    .pll_locked (locked),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  typedef struct packed {
    logic          resetb;
    logic          bypass;
    logic          ready;
    logic          fault;
    logic          lost;
    logic [RW-1:0] rc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase name, cycles spent in it, failures since last success,
  // and a short history of sampled LOCK values.
  string m_phase = "HOLD";
  int    m_elapsed = 0;
  int    m_fails = 0;
  logic  m_hist1 = 1'b0;
  logic  m_hist2 = 1'b0;
  logic  m_lost = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter(input string ph);
    m_phase   = ph;
    m_elapsed = 0;
  endtask

  task automatic attempt_failed();
    if (m_fails == int'(MR)) begin
      enter("FAULT");
    end else begin
      m_fails++;
      enter("HOLD");
    end
  endtask

  // One clock edge of the model, using the inputs the DUT samples at that edge.
  task automatic model_edge();
    logic seen;
    if (!rst_n) begin
      enter("HOLD");
      m_fails = 0;
      m_hist1 = 1'b0;
      m_hist2 = 1'b0;
      m_lost  = 1'b0;
      return;
    end
    seen    = m_hist2;
    m_hist2 = m_hist1;
    m_hist1 = locked;
    m_lost  = 1'b0;
    if (restart) begin
      enter("HOLD");
      m_fails = 0;
      return;
    end
    if (m_phase == "HOLD") begin
      m_elapsed++;
      if (m_elapsed == int'(RC)) enter("WAIT");
    end else if (m_phase == "WAIT") begin
      if (seen) enter("STAB");
      else begin
        m_elapsed++;
        if (m_elapsed == int'(LT)) attempt_failed();
      end
    end else if (m_phase == "STAB") begin
      if (!seen) attempt_failed();
      else begin
        m_elapsed++;
        if (m_elapsed == int'(SC)) begin
          enter("RUN");
          m_fails = 0;
        end
      end
    end else if (m_phase == "RUN") begin
      if (!seen) begin
        m_lost = 1'b1;
        attempt_failed();
      end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.resetb = (m_phase == "WAIT") || (m_phase == "STAB") || (m_phase == "RUN");
    e.bypass = 1'b0;
    e.ready  = (m_phase == "RUN");
    e.fault  = (m_phase == "FAULT");
    e.lost   = m_lost;
    e.rc     = RW'(m_fails);
`ifdef PLL_BYPASS_FALLBACK_EN
    if (m_phase == "FAULT") begin
      e.resetb = 1'b1;
      e.bypass = 1'b1;
      e.ready  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Advance n edges; inputs may be changed by the caller 1 time unit after each edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      q.push_back(expect_now());
      #1;
    end
  endtask

  // Monitor: one prediction per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pll_resetb", 8'(pll_resetb), 8'(e.resetb));
      chk("pll_bypass", 8'(pll_bypass), 8'(e.bypass));
      chk("ready", 8'(ready), 8'(e.ready));
      chk("fault", 8'(fault), 8'(e.fault));
      chk("lock_lost", 8'(lock_lost), 8'(e.lost));
      chk("retry_count", 8'(retry_count), 8'(e.rc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    #2;
    chk("reset pll_resetb", 8'(pll_resetb), 8'd0);
    chk("reset ready", 8'(ready), 8'd0);
    chk("reset fault", 8'(fault), 8'd0);
    chk("reset retry_count", 8'(retry_count), 8'd0);
    cycles(2);
    rst_n = 1'b1;

    // Normal lock: RESETB after RC cycles, ready 11 cycles after LOCK.
    n = 0;
    while (pll_resetb !== 1'b1 && n < 50) begin
      cycles(1);
      n++;
    end
    chk("cycles to pll_resetb", 8'(n), 8'd4);
    cycles(5);
    locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      cycles(1);
      n++;
    end
    chk("cycles lock to ready", 8'(n), 8'd11);
    chk("normal retry_count", 8'(retry_count), 8'd0);
    cycles(10);

    // Lock loss in RUN.
    locked = 1'b0;
    cycles(30);
    locked = 1'b1;
    cycles(40);
    chk("relock ready", 8'(ready), 8'd1);
    chk("relock retry_count", 8'(retry_count), 8'd0);

    // Chatter in STABILIZE at stable count 5.
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(8);
    locked = 1'b0;
    cycles(1);
    locked = 1'b1;
    cycles(2);
    chk("chatter retry_count", 8'(retry_count), 8'd1);
    chk("chatter pll_resetb", 8'(pll_resetb), 8'd0);
    cycles(40);

    // Never lock, into FAULT.
    locked = 1'b0;
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(3 * (RC + LT) + 6);
    chk("fault flag", 8'(fault), 8'd1);
    chk("fault retry_count", 8'(retry_count), 8'd2);
`ifdef PLL_BYPASS_FALLBACK_EN
    chk("fault pll_bypass", 8'(pll_bypass), 8'd1);
    chk("fault ready", 8'(ready), 8'd1);
`else
    chk("fault pll_resetb", 8'(pll_resetb), 8'd0);
    chk("fault ready", 8'(ready), 8'd0);
`endif

    // Recovery from FAULT via restart.
    locked = 1'b1;
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    chk("restart fault", 8'(fault), 8'd0);
    chk("restart retry_count", 8'(retry_count), 8'd0);
    cycles(40);
    chk("recovered ready", 8'(ready), 8'd1);

    // Randomized lock behaviour with occasional multi-cycle restarts.
    for (int i = 0; i < 40; i++) begin
      locked = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        restart = 1'b1;
        cycles($urandom_range(1, 3));
        restart = 1'b0;
      end
      cycles($urandom_range(1, 40));
    end

    // Async reset mid-RUN, between clock edges.
    locked = 1'b1;
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(30);
    chk("pre-reset ready", 8'(ready), 8'd1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("async ready", 8'(ready), 8'd0);
    chk("async pll_resetb", 8'(pll_resetb), 8'd0);
    chk("async fault", 8'(fault), 8'd0);
    chk("async lock_lost", 8'(lock_lost), 8'd0);
    chk("async retry_count", 8'(retry_count), 8'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(30);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
